// File: rtl/audio_pkg.sv
// Shared audio codec constants and width helpers for the capture and playback paths.
package audio_pkg;
  localparam int AUDIO_WIDTH  = 16;
  localparam int SCK_DIV_LOG2 = 4;

  // Counter width: lrck half (log2 WIDTH sck periods) + sck divider + lrck bit.
  function automatic int cnt_width(input int width, input int div_log2);
    return $clog2(width) + div_log2 + 1;
  endfunction

  localparam int AUDIO_CNT_W   = cnt_width(AUDIO_WIDTH, SCK_DIV_LOG2);
  localparam int AUDIO_CNT_MSB = AUDIO_CNT_W - 1;
endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running I2S timing counter: derives mclk/sck/lrck and the mid-sck-high strobe.
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int WIDTH    = AUDIO_WIDTH,
  parameter int DIV_LOG2 = SCK_DIV_LOG2,
  localparam int CW      = cnt_width(WIDTH, DIV_LOG2)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic          strobe,
  output logic          mclk,
  output logic          sck,
  output logic          lrck
);

  // First clk of the sck high phase: data is mid-bit and stable here.
  localparam logic [DIV_LOG2-1:0] STROBE_PH = {1'b1, {(DIV_LOG2-1){1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt + 1'b1;
  end

  assign mclk   = cnt[1];
  assign sck    = cnt[DIV_LOG2-1];
  assign lrck   = cnt[CW-1];
  assign strobe = (cnt[DIV_LOG2-1:0] == STROBE_PH);

endmodule

// File: rtl/i2s_line_in_rx.sv
// I2S line-in capture: deserialises codec ADC data into left/right pairs behind a valid/ready register.
module i2s_line_in_rx
  import audio_pkg::*;
#(
  parameter int WIDTH    = AUDIO_WIDTH,
  parameter int DIV_LOG2 = SCK_DIV_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             audio_sdout,
  output logic             audio_mclk,
  output logic             audio_lrck,
  output logic             audio_sck,
  output logic [WIDTH-1:0] left_sample,
  output logic [WIDTH-1:0] right_sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun
);

  localparam int CW = cnt_width(WIDTH, DIV_LOG2);
  localparam int KW = CW - DIV_LOG2;
  localparam logic [KW-1:0] K_LEFT_DONE = KW'(WIDTH);

  logic [CW-1:0]    cnt;
  logic             strobe;
  logic [KW-1:0]    k;
  logic [WIDTH-2:0] shift;
  logic [WIDTH-1:0] left_hold;
  logic [WIDTH-1:0] word;
  logic             have_left;
  logic             publish;
  logic             xfer;
  logic             unused_cnt_lo;

  i2s_clk_gen #(
    .WIDTH    (WIDTH),
    .DIV_LOG2 (DIV_LOG2)
  ) u_clk_gen (
    .clk    (clk),
    .rst    (rst),
    .cnt    (cnt),
    .strobe (strobe),
    .mclk   (audio_mclk),
    .sck    (audio_sck),
    .lrck   (audio_lrck)
  );

  assign k             = cnt[CW-1:DIV_LOG2];
  assign unused_cnt_lo = ^cnt[DIV_LOG2-1:0];

  // One-bit I2S delay: the word's LSB lands in the first sck of the opposite half.
  assign word    = {shift, audio_sdout};
  assign publish = strobe && (k == '0) && have_left;
  assign xfer    = sample_valid && sample_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift     <= '0;
      left_hold <= '0;
      have_left <= 1'b0;
    end else if (strobe) begin
      shift <= word[WIDTH-2:0];
      if (k == K_LEFT_DONE) begin
        left_hold <= word;
        have_left <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (publish) begin
        left_sample  <= left_hold;
        right_sample <= word;
        sample_valid <= 1'b1;
        overrun      <= sample_valid && !sample_ready;
      end else if (xfer) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_line_in_rx.sv
// Directed/randomised bench: an edge-driven I2S codec model feeds frames, expected pairs come from its queue.
module tb_i2s_line_in_rx;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        audio_sdout = 1'b0;
  logic        sample_ready = 1'b0;
  logic        audio_mclk, audio_lrck, audio_sck;
  logic [15:0] left_sample, right_sample;
  logic        sample_valid, overrun;

  int checks = 0;
  int failures = 0;
  int n = 0;

  pair_t stim_q[$];
  pair_t exp_q[$];

  i2s_line_in_rx dut (
    .clk          (clk),
    .rst          (rst),
    .audio_sdout  (audio_sdout),
    .audio_mclk   (audio_mclk),
    .audio_lrck   (audio_lrck),
    .audio_sck    (audio_sck),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Codec model: counts sck falling edges, changes data just after each fall,
  // MSB one sck after each lrck edge; a finished frame is queued as the expected pair.
  pair_t cur;
  logic  prev_r0 = 1'b0;
  int    pos = 0;
  bit    half = 1'b0;
  bit    last_rst = 1'b0;

  always @(negedge audio_sck or posedge rst or negedge rst) begin
    #1;
    if (!rst) begin
      last_rst = 1'b0;
    end else begin
      if (!last_rst) begin
        last_rst = 1'b1;
        exp_q.delete();
        half = 1'b0;
        pos  = 0;
        if (stim_q.size() > 0) cur = stim_q.pop_front();
        else begin cur.l = 16'($urandom); cur.r = 16'($urandom); end
      end else begin
        pos++;
        if (pos == 16) begin
          pos  = 0;
          half = !half;
          if (!half) begin
            exp_q.push_back(cur);
            prev_r0 = cur.r[0];
            if (stim_q.size() > 0) cur = stim_q.pop_front();
            else begin cur.l = 16'($urandom); cur.r = 16'($urandom); end
          end
        end
      end
      if (pos == 0) audio_sdout = half ? cur.l[0] : prev_r0;
      else          audio_sdout = half ? cur.r[16-pos] : cur.l[16-pos];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic pop_exp(output pair_t p);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL exp_queue_empty observed=0 expected=1");
      p = '0;
    end else p = exp_q.pop_front();
  endtask

  task automatic chk_pair(input string tag, input pair_t p);
    chk({tag, "_left"}, 32'(left_sample), 32'(p.l));
    chk({tag, "_right"}, 32'(right_sample), 32'(p.r));
  endtask

  function automatic int pub(input int m);
    return 521 + 512*m;
  endfunction

  initial begin
    pair_t p, held;
    int first_v = -1;
    int mclk_rise = -1, sck_rise = -1, n_mclk = 0, n_lrck_edge = 0;
    int bad_mclk = 0, bad_sck = 0, bad_lrck = 0, bad_ov = 0, ov_pulses = 0, v_drop = 0;
    logic p_mclk = 1'b0, p_sck = 1'b0, p_lrck = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_left", 32'(left_sample), 0);
    chk("rst_right", 32'(right_sample), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_clocks", {29'd0, audio_mclk, audio_sck, audio_lrck}, 0);

    stim_q.push_back({16'hA55A, 16'h0F0F});
    stim_q.push_back({16'h8000, 16'h7FFF});
    stim_q.push_back({16'hFFFF, 16'h0001});
    stim_q.push_back({16'h8000, 16'h7FFF});
    stim_q.push_back({16'hFFFF, 16'h0001});
    @(negedge clk);
    rst = 1'b1;
    n = 0;

    // First frame latency and clock shapes
    for (int i = 0; i < 521; i++) begin
      step();
      if (sample_valid && first_v < 0) first_v = n;
      if (overrun) bad_ov++;
      if (audio_mclk && !p_mclk) begin
        if (mclk_rise >= 0 && n - mclk_rise != 4) bad_mclk++;
        mclk_rise = n;
        n_mclk++;
      end
      if (audio_sck && !p_sck) begin
        if (sck_rise >= 0 && n - sck_rise != 16) bad_sck++;
        sck_rise = n;
      end
      if (!audio_sck && p_sck && n - sck_rise != 8) bad_sck++;
      if (audio_lrck !== ((n % 512) >= 256)) bad_lrck++;
      if (audio_lrck != p_lrck) begin
        n_lrck_edge++;
        if (!(p_sck && !audio_sck)) bad_lrck++;
      end
      p_mclk = audio_mclk; p_sck = audio_sck; p_lrck = audio_lrck;
    end
    chk("first_valid_clk", 32'(first_v), 521);
    chk("mclk_period", 32'(bad_mclk), 0);
    chk("mclk_seen", 32'(n_mclk > 100), 1);
    chk("sck_period_duty", 32'(bad_sck), 0);
    chk("lrck_window_edges", 32'(bad_lrck), 0);
    chk("lrck_edge_count", 32'(n_lrck_edge), 2);
    chk("first_left_const", 32'(left_sample), 32'h A55A);
    chk("first_right_const", 32'(right_sample), 32'h0F0F);
    pop_exp(p);
    chk_pair("first", p);

    // Ready held high: every pair delivered, one per frame
    sample_ready = 1'b1;
    for (int m = 1; m <= 4; m++) begin
      while (n < pub(m) - 1) begin
        step();
        if (overrun) bad_ov++;
      end
      chk("b_drained", 32'(sample_valid), 0);
      step();
      chk("b_valid", 32'(sample_valid), 1);
      pop_exp(p);
      chk_pair("b_pair", p);
    end
    step();
    chk("b_last_taken", 32'(sample_valid), 0);
    chk("b_no_overrun", 32'(bad_ov), 0);
    sample_ready = 1'b0;

    // Ready held low for three publishes: overwrite and overrun
    while (n < pub(7)) begin
      step();
      if (overrun) ov_pulses++;
      if (n >= pub(5) && !sample_valid) v_drop++;
      for (int m = 5; m <= 7; m++)
        if (n == pub(m)) begin
          pop_exp(p);
          chk_pair("c_pair", p);
          chk("c_overrun_at_pub", 32'(overrun), 32'(m > 5));
          held = p;
        end
    end
    while (n < pub(8) - 1) begin
      step();
      if (overrun) ov_pulses++;
      if (!sample_valid) v_drop++;
    end
    chk("c_overrun_pulses", 32'(ov_pulses), 2);
    chk("c_valid_held", 32'(v_drop), 0);
    chk_pair("c_stable", held);

    // Publish and transfer in the same cycle
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    chk("d_valid", 32'(sample_valid), 1);
    chk("d_overrun", 32'(overrun), 0);
    pop_exp(p);
    chk_pair("d_pair", p);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    chk("d_drained", 32'(sample_valid), 0);

    // Reset mid right word (cnt=300)
    while ((n % 512) != 300) step();
    stim_q.push_back({16'hC3C3, 16'h3C3C});
    rst = 1'b0;
    #1;
    chk("e_rst_left", 32'(left_sample), 0);
    chk("e_rst_right", 32'(right_sample), 0);
    chk("e_rst_valid_ov", {30'd0, sample_valid, overrun}, 0);
    chk("e_rst_clocks", {29'd0, audio_mclk, audio_sck, audio_lrck}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    first_v = -1;
    for (int i = 0; i < 521; i++) begin
      step();
      if (sample_valid && first_v < 0) first_v = n;
    end
    chk("e_first_valid_clk", 32'(first_v), 521);
    chk("e_left_const", 32'(left_sample), 32'hC3C3);
    chk("e_right_const", 32'(right_sample), 32'h3C3C);
    pop_exp(p);
    chk_pair("e_pair", p);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
